// File: rtl/cdc_4phase_rsp.sv
// Responder half of a 4-phase req/ack handshake: synchronizes the async request,
// hands it out on a local valid/ready port, and returns the local response with ack.
module cdc_4phase_rsp #(
  parameter int unsigned REQ_WIDTH   = 32,
  parameter int unsigned RSP_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 async_req_i,
  input  logic [REQ_WIDTH-1:0] async_req_data_i,
  output logic                 async_ack_o,
  output logic [RSP_WIDTH-1:0] async_rsp_data_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [REQ_WIDTH-1:0] req_data_o,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [RSP_WIDTH-1:0] rsp_data_i
);

  typedef enum logic [1:0] {
    IDLE              = 2'd0,
    REQ_PENDING       = 2'd1,
    WAIT_RSP          = 2'd2,
    WAIT_REQ_DEASSERT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_synced;
  logic                   req_capture, rsp_capture, ack_clr;
  logic                   ack_q;
  logic [REQ_WIDTH-1:0]   req_q;
  logic [RSP_WIDTH-1:0]   rsp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], async_req_i};
  end

  assign req_synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:              if (req_synced)  state_d = REQ_PENDING;
      REQ_PENDING:       if (req_ready_i) state_d = WAIT_RSP;
      WAIT_RSP:          if (rsp_valid_i) state_d = WAIT_REQ_DEASSERT;
      WAIT_REQ_DEASSERT: if (!req_synced) state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Handshake outputs come from the state register alone; captures are enables only.
  always_comb begin
    req_valid_o = (state_q == REQ_PENDING);
    rsp_ready_o = (state_q == WAIT_RSP);
    req_capture = (state_q == IDLE) && req_synced;
    rsp_capture = (state_q == WAIT_RSP) && rsp_valid_i;
    ack_clr     = (state_q == WAIT_REQ_DEASSERT) && !req_synced;
  end

  // Response data and ack launch on the same edge; the far side's ack sync covers skew.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
      rsp_q <= '0;
      ack_q <= 1'b0;
    end else begin
      if (req_capture) req_q <= async_req_data_i;
      if (rsp_capture) begin
        rsp_q <= rsp_data_i;
        ack_q <= 1'b1;
      end else if (ack_clr) begin
        ack_q <= 1'b0;
      end
    end
  end

  assign req_data_o       = req_q;
  assign async_rsp_data_o = rsp_q;
  assign async_ack_o      = ack_q;

endmodule

// File: tb/tb_cdc_4phase_rsp.sv
// Bench for cdc_4phase_rsp: transaction-flag model checked every cycle, plus
// directed scenarios with hand-computed latencies and payloads.
module tb_cdc_4phase_rsp;
  localparam int SS = 2;
  localparam int RW = 32;
  localparam int SW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          areq;
  logic [RW-1:0] areq_data;
  logic          ack;
  logic [SW-1:0] arsp;
  logic          rvalid;
  logic          rready;
  logic [RW-1:0] rdata;
  logic          svalid;
  logic          sready;
  logic [SW-1:0] sdata;

  int n_chk  = 0;
  int n_fail = 0;

  cdc_4phase_rsp #(.REQ_WIDTH(RW), .RSP_WIDTH(SW), .SYNC_STAGES(SS)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .async_req_i      (areq),
    .async_req_data_i (areq_data),
    .async_ack_o      (ack),
    .async_rsp_data_o (arsp),
    .req_valid_o      (rvalid),
    .req_ready_i      (rready),
    .req_data_o       (rdata),
    .rsp_valid_i      (svalid),
    .rsp_ready_o      (sready),
    .rsp_data_i       (sdata)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one transaction at a time, tracked as busy/delivered/responded flags.
  // The responder sees the async request SS clock edges late.
  logic [SS-1:0] m_hist;
  logic          m_busy, m_deliv, m_resp;
  logic [RW-1:0] m_req;
  logic [SW-1:0] m_rsp;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_hist <= '0; m_busy <= 1'b0; m_deliv <= 1'b0; m_resp <= 1'b0;
      m_req  <= '0; m_rsp  <= '0;
    end else begin
      if (!m_busy) begin
        if (m_hist[SS-1]) begin m_busy <= 1'b1; m_req <= areq_data; end
      end else if (!m_deliv) begin
        if (rready) m_deliv <= 1'b1;
      end else if (!m_resp) begin
        if (svalid) begin m_resp <= 1'b1; m_rsp <= sdata; end
      end else if (!m_hist[SS-1]) begin
        m_busy <= 1'b0; m_deliv <= 1'b0; m_resp <= 1'b0;
      end
      m_hist <= {m_hist[SS-2:0], areq};
    end
  end

  // Per-cycle compare plus a log of local transfers and ack pulses.
  logic [RW-1:0] req_log[$];
  logic [SW-1:0] rsp_log[$];
  logic          ack_prev = 1'b0;

  always @(negedge clk_i) begin
    check("model_req_valid", {31'b0, rvalid}, {31'b0, m_busy && !m_deliv});
    check("model_rsp_ready", {31'b0, sready}, {31'b0, m_deliv && !m_resp});
    check("model_ack",       {31'b0, ack},    {31'b0, m_resp});
    check("model_rsp_data",  arsp,  m_rsp);
    check("model_req_data",  rdata, m_req);
    if (rst_ni && rvalid && rready) req_log.push_back(rdata);
    if (ack && !ack_prev) rsp_log.push_back(arsp);
    ack_prev = ack;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (rvalid !== 1'b1 && n < 40) begin tick(); n++; end
    check(name, {31'b0, rvalid}, 32'd1);
  endtask

  task automatic wait_rsp_ready(input string name);
    int n = 0;
    while (sready !== 1'b1 && n < 40) begin tick(); n++; end
    check(name, {31'b0, sready}, 32'd1);
  endtask

  task automatic wait_ack(input string name, input logic lvl);
    int n = 0;
    while (ack !== lvl && n < 40) begin tick(); n++; end
    check(name, {31'b0, ack}, {31'b0, lvl});
  endtask

  task automatic do_txn(input logic [RW-1:0] d, input logic [SW-1:0] r);
    areq_data = d; areq = 1'b1;
    wait_valid("txn_valid");
    rready = 1'b1; tick(); rready = 1'b0;
    wait_rsp_ready("txn_rsp_ready");
    svalid = 1'b1; sdata = r; tick(); svalid = 1'b0;
    check("txn_ack_data", arsp, r);
    areq = 1'b0;
    wait_ack("txn_ack_fall", 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; areq = 1'b0; areq_data = '0;
    rready = 1'b0; svalid = 1'b0; sdata = '0;
    tick(3);
    check("rst_ack",       {31'b0, ack},    32'd0);
    check("rst_rsp_data",  arsp,            32'd0);
    check("rst_req_valid", {31'b0, rvalid}, 32'd0);
    check("rst_rsp_ready", {31'b0, sready}, 32'd0);
    check("rst_req_data",  rdata,           32'd0);
    rst_ni = 1'b1;
    tick(2);

    // Basic transaction: valid 3 edges after req rise, ack falls 3 edges after drop.
    rready = 1'b1;
    areq_data = 32'hDEADBEEF; areq = 1'b1;
    tick(2);
    check("basic_valid_early", {31'b0, rvalid}, 32'd0);
    tick();
    check("basic_valid_lat3",  {31'b0, rvalid}, 32'd1);
    check("basic_req_data",    rdata, 32'hDEADBEEF);
    tick();
    check("basic_rsp_ready",   {31'b0, sready}, 32'd1);
    rready = 1'b0;
    tick();
    svalid = 1'b1; sdata = 32'h12345678;
    tick();
    svalid = 1'b0;
    check("basic_ack_rise",    {31'b0, ack}, 32'd1);
    check("basic_ack_data",    arsp, 32'h12345678);
    areq = 1'b0;
    tick(2);
    check("basic_ack_hold",    {31'b0, ack}, 32'd1);
    tick();
    check("basic_ack_fall3",   {31'b0, ack}, 32'd0);
    tick(2);

    // Local backpressure on both sides.
    areq_data = 32'hCAFE0001; areq = 1'b1;
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", {31'b0, rvalid}, 32'd1);
      check("bp_data_stable", rdata, 32'hCAFE0001);
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_ack_low", {31'b0, ack}, 32'd0);
      check("bp_rsp_ready_held", {31'b0, sready}, 32'd1);
      tick();
    end
    svalid = 1'b1; sdata = 32'h55667788; tick(); svalid = 1'b0;
    check("bp_ack_rise", {31'b0, ack}, 32'd1);
    check("bp_ack_data", arsp, 32'h55667788);
    areq = 1'b0;
    wait_ack("bp_ack_fall", 1'b0);
    tick(2);

    // Spurious response in IDLE and REQ_PENDING is ignored.
    svalid = 1'b1; sdata = 32'hAAAAAAAA;
    tick(3);
    check("spur_idle_rsp_ready", {31'b0, sready}, 32'd0);
    check("spur_idle_rsp_data",  arsp, 32'h55667788);
    areq_data = 32'h00000003; areq = 1'b1;
    wait_valid("spur_valid");
    tick(3);
    check("spur_pend_rsp_ready", {31'b0, sready}, 32'd0);
    check("spur_pend_rsp_data",  arsp, 32'h55667788);
    check("spur_pend_ack",       {31'b0, ack}, 32'd0);
    svalid = 1'b0;
    rready = 1'b1; tick(); rready = 1'b0;
    wait_rsp_ready("spur_rsp_ready");
    svalid = 1'b1; sdata = 32'h00000077; tick(); svalid = 1'b0;
    check("spur_ack_data", arsp, 32'h00000077);
    areq = 1'b0;
    wait_ack("spur_ack_fall", 1'b0);
    tick(2);

    // Back-to-back transactions.
    req_log.delete(); rsp_log.delete();
    do_txn(32'd1, 32'h10);
    do_txn(32'd2, 32'h20);
    do_txn(32'd3, 32'h30);
    check("b2b_req_count", req_log.size(), 32'd3);
    check("b2b_rsp_count", rsp_log.size(), 32'd3);
    if (req_log.size() == 3 && rsp_log.size() == 3) begin
      check("b2b_req0", req_log[0], 32'd1);
      check("b2b_req1", req_log[1], 32'd2);
      check("b2b_req2", req_log[2], 32'd3);
      check("b2b_rsp0", rsp_log[0], 32'h10);
      check("b2b_rsp1", rsp_log[1], 32'h20);
      check("b2b_rsp2", rsp_log[2], 32'h30);
    end

    // Local reset in WAIT_REQ_DEASSERT with the request still high: duplicate delivery.
    areq_data = 32'hBEEF0005; areq = 1'b1;
    wait_valid("rst_txn_valid");
    rready = 1'b1; tick(); rready = 1'b0;
    wait_rsp_ready("rst_txn_rsp_ready");
    svalid = 1'b1; sdata = 32'h00000050; tick(); svalid = 1'b0;
    check("rst_txn_ack", {31'b0, ack}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async_ack",      {31'b0, ack},    32'd0);
    check("rst_async_rsp_data", arsp,            32'd0);
    check("rst_async_req_data", rdata,           32'd0);
    check("rst_async_valid",    {31'b0, rvalid}, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    tick(2);
    check("dup_valid_early", {31'b0, rvalid}, 32'd0);
    tick();
    check("dup_valid_lat3",  {31'b0, rvalid}, 32'd1);
    check("dup_req_data",    rdata, 32'hBEEF0005);
    rready = 1'b1; tick(); rready = 1'b0;
    wait_rsp_ready("dup_rsp_ready");
    svalid = 1'b1; sdata = 32'h00000051; tick(); svalid = 1'b0;
    areq = 1'b0;
    wait_ack("dup_ack_fall", 1'b0);
    tick(2);

    // Initiator drops the request while REQ_PENDING: one-cycle ack pulse.
    areq_data = 32'h00000006; areq = 1'b1;
    wait_valid("drop_valid");
    areq = 1'b0;
    tick(4);
    check("drop_valid_kept", {31'b0, rvalid}, 32'd1);
    rready = 1'b1; tick(); rready = 1'b0;
    wait_rsp_ready("drop_rsp_ready");
    svalid = 1'b1; sdata = 32'h00000060; tick(); svalid = 1'b0;
    check("drop_ack_rise", {31'b0, ack}, 32'd1);
    check("drop_ack_data", arsp, 32'h00000060);
    tick();
    check("drop_ack_1cyc", {31'b0, ack}, 32'd0);
    tick();
    check("drop_idle_valid", {31'b0, rvalid}, 32'd0);
    check("drop_idle_ready", {31'b0, sready}, 32'd0);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
